// File: rtl/mips_bus_mem_slave.sv
// Word-addressed memory slave for the mips_cpu_bus interface. It provides programmable wait
// states, base-address decode, an optional byte-lane swap, an error pulse and a debug read port.
module mips_bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          BYTE_SWAP   = 1'b1,
  parameter              INIT_FILE   = "",
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   address,
  input  logic          read,
  input  logic          write,
  input  logic [3:0]    byteenable,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          waitrequest,
  output logic          error,
  input  logic [AW-1:0] dbg_index,
  output logic [31:0]   dbg_word
);

  localparam int unsigned CW = 4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          req_c;
  logic          done_c;

  logic [31:0]   mem [DEPTH_WORDS];

  function automatic logic [31:0] lane_map(input logic [31:0] w);
    return BYTE_SWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  function automatic logic [3:0] be_map(input logic [3:0] be);
    return BYTE_SWAP ? {be[0], be[1], be[2], be[3]} : be;
  endfunction

  assign req_c       = read | write;
  assign done_c      = req_c && (cnt == CW'(WAIT_CYCLES));
  // Gated by reset_n so the bus is released as soon as reset is applied.
  assign waitrequest = reset_n && req_c && (cnt != CW'(WAIT_CYCLES));

  // Address decode
  logic [31:0]   offset_c;
  logic          addr_ok_c;
  logic          bus_err_c;
  logic [AW-1:0] idx_c;

  assign offset_c  = address - BASE_ADDR;
  assign addr_ok_c = (address >= BASE_ADDR) && ((offset_c >> (AW + 2)) == 32'd0) &&
                     (address[1:0] == 2'b00);
  assign idx_c     = offset_c[AW+1:2];
  assign bus_err_c = (read && write) || (!addr_ok_c && (address != 32'd0));

  // Wait-state sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!req_c || done_c) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      state_nxt = ST_WAIT;
      cnt_nxt   = cnt + CW'(1);
    end
  end

  // Memory array
  logic        wr_en_c;
  logic [31:0] wd_mem_c;
  logic [3:0]  be_mem_c;

  assign wr_en_c  = done_c && write && !read && addr_ok_c;
  assign wd_mem_c = lane_map(writedata);
  assign be_mem_c = be_map(byteenable);

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int j = 0; j < 4; j++) begin
        if (be_mem_c[j]) mem[idx_c][8*j +: 8] <= wd_mem_c[8*j +: 8];
      end
    end
  end

  // Read path: disabled lanes return zero
  logic [31:0] be_mask_c;
  logic [31:0] rd_bus_c;

  assign be_mask_c = {{8{byteenable[3]}}, {8{byteenable[2]}},
                      {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign rd_bus_c  = lane_map(mem[idx_c]) & be_mask_c;
  assign dbg_word  = mem[dbg_index];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      error    <= 1'b0;
    end else begin
      error <= done_c && bus_err_c;
      if (done_c) begin
        if (bus_err_c)                    readdata <= '0;
        else if (read && !addr_ok_c)      readdata <= '0;
        else if (read)                    readdata <= rd_bus_c;
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_slave.sv
// Randomised scoreboard bench for mips_bus_mem_slave against a bus-view memory model.
module tb_mips_bus_mem_slave;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;

  logic        clk, reset_n;
  logic [31:0] address, writedata, readdata, dbg_word;
  logic        read, write, waitrequest, error;
  logic [3:0]  byteenable;
  logic [9:0]  dbg_index;

  mips_bus_mem_slave #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BYTE_SWAP(1'b1), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .error(error), .dbg_index(dbg_index), .dbg_word(dbg_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  int          tests, fails;
  exp_t        q[$];
  exp_t        e_mon;
  bit          pend;
  logic [31:0] model [DEPTH];   // bus-view word contents
  bit          known [DEPTH];
  logic [31:0] last_rd;
  int          pool [8] = '{0, 1, 2, 66, 67, 100, 511, 1023};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] w);
    return {<<8{w}};
  endfunction

  function automatic logic [31:0] mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Monitor: a completion seen at one negedge is checked at the next
  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_completion: got readdata %h error %b expected none", readdata, error);
      end else begin
        e_mon = q.pop_front();
        check("readdata", readdata, e_mon.data);
        check("error", 32'(error), 32'(e_mon.err));
      end
    end else begin
      check("error_idle", 32'(error), 32'd0);
    end
    pend = reset_n && (read || write) && !waitrequest;
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    int   waits;
    bit   ok, err;
    int   idx, di;
    exp_t x;
    ok  = (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH)) && (a[1:0] == 2'b00);
    idx = ok ? int'((a - BASE) >> 2) : 0;
    err = (rd && wr) || (!ok && a != 32'd0);
    di  = idx;
    address = a; byteenable = be; writedata = wd; read = rd; write = wr;
    dbg_index = 10'(di);
    waits = 0;
    @(negedge clk);
    while (waitrequest === 1'b1 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check("wait_cycles", 32'(waits), 32'(WAITC));
    if (err) last_rd = '0;
    else if (rd) last_rd = (a == 32'd0) ? 32'd0 : (model[idx] & mask(be));
    else if (ok) begin
      model[idx] = (model[idx] & ~mask(be)) | (wd & mask(be));
      if (be == 4'hF) known[idx] = 1'b1;
    end
    x.data = last_rd;
    x.err  = err;
    q.push_back(x);
    @(posedge clk); #1;
    if (known[di]) check("dbg_word", dbg_word, rev(model[di]));
  endtask

  task automatic idle();
    read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad [5];
    int p, r;
    tests = 0; fails = 0; pend = 1'b0; last_rd = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    byteenable = '0; writedata = '0; dbg_index = '0;
    #23;
    check("reset_readdata", readdata, 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_waitrequest", 32'(waitrequest), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (pool[i]) access(1'b0, 1'b1, BASE + 32'(4 * pool[i]), 4'hF, $urandom);
    idle();

    // Read word 0, then a full-word write with swapped memory order
    access(1'b1, 1'b0, BASE, 4'hF, 32'd0);
    idle();
    access(1'b0, 1'b1, BASE + 32'h108, 4'hF, 32'h11223344);
    check("swap_dbg66", dbg_word, 32'h44332211);
    access(1'b1, 1'b0, BASE + 32'h108, 4'hF, 32'd0);
    idle();

    // Partial write into a zeroed word
    access(1'b0, 1'b1, BASE + 32'h10C, 4'hF, 32'd0);
    access(1'b0, 1'b1, BASE + 32'h10C, 4'b0011, 32'hAABBCCDD);
    check("partial_dbg67", dbg_word, 32'hDDCC0000);
    access(1'b1, 1'b0, BASE + 32'h10C, 4'hF, 32'd0);
    idle();
    check("partial_readback", readdata, 32'h0000CCDD);

    // Out-of-range read and simultaneous read/write
    access(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'd0);
    access(1'b1, 1'b1, BASE + 32'h108, 4'hF, 32'hFFFFFFFF);
    idle();
    check("err_readdata", readdata, 32'd0);

    // Abort after one wait cycle
    address = BASE; byteenable = 4'hF; read = 1'b1;
    @(negedge clk);
    check("abort_wait_high", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    read = 1'b0;
    idle();
    access(1'b1, 1'b0, BASE, 4'hF, 32'd0);
    idle();

    // Reset mid-wait
    access(1'b1, 1'b0, BASE + 32'h108, 4'hF, 32'd0);
    idle();
    address = BASE + 32'd4; byteenable = 4'hF; read = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_waitrequest", 32'(waitrequest), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    last_rd = '0;
    read = 1'b0;
    foreach (pool[i]) begin
      dbg_index = 10'(pool[i]);
      #1;
      check("rst_dbg_keep", dbg_word, rev(model[pool[i]]));
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      p = pool[$urandom_range(0, 7)];
      r = $urandom_range(0, 9);
      bad[0] = BASE + 32'(4 * DEPTH);
      bad[1] = BASE + 32'(4 * p) + 32'($urandom_range(1, 3));
      bad[2] = BASE - 32'd4;
      bad[3] = 32'd0;
      bad[4] = 32'hFFFFFFFC;
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) access(1'b1, 1'b0, bad[$urandom_range(0, 4)], 4'($urandom), 32'd0);
        else access(1'b0, 1'b1, bad[$urandom_range(0, 4)], 4'($urandom), $urandom);
      end else if (r == 1) access(1'b1, 1'b1, BASE + 32'(4 * p), 4'($urandom), $urandom);
      else if (r < 6) access(1'b1, 1'b0, BASE + 32'(4 * p), 4'($urandom), 32'd0);
      else access(1'b0, 1'b1, BASE + 32'(4 * p), 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    idle();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
